alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu.sv | 43 ++++
 rtl/alu_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter and its ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // ALU select codes
  localparam logic [SEL_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [SEL_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [SEL_W-1:0] ALU_MUL  = 4'h2;
  localparam logic [SEL_W-1:0] ALU_DIV  = 4'h3;
  localparam logic [SEL_W-1:0] ALU_SHL  = 4'h4;
  localparam logic [SEL_W-1:0] ALU_SHR  = 4'h5;
  localparam logic [SEL_W-1:0] ALU_ROL  = 4'h6;
  localparam logic [SEL_W-1:0] ALU_ROR  = 4'h7;
  localparam logic [SEL_W-1:0] ALU_AND  = 4'h8;
  localparam logic [SEL_W-1:0] ALU_OR   = 4'h9;
  localparam logic [SEL_W-1:0] ALU_XOR  = 4'hA;
  localparam logic [SEL_W-1:0] ALU_NOR  = 4'hB;
  localparam logic [SEL_W-1:0] ALU_NAND = 4'hC;
  localparam logic [SEL_W-1:0] ALU_XNOR = 4'hD;
  localparam logic [SEL_W-1:0] ALU_GT   = 4'hE;
  localparam logic [SEL_W-1:0] ALU_EQ   = 4'hF;

  // Latched operation payload
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } op_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; carry-out is the A+B carry for every select.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [DATA_W-1:0] alu_out_o,
  output logic              carry_out_o
);

  logic [DATA_W:0]     sum_ext;
  logic [2*DATA_W-1:0] prod;

  assign sum_ext     = {1'b0, a_i} + {1'b0, b_i};
  assign prod        = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
  assign carry_out_o = sum_ext[DATA_W];

  // Result mux; divide by zero saturates to all ones
  always_comb begin
    alu_out_o = '0;
    case (sel_i)
      ALU_ADD:  alu_out_o = sum_ext[DATA_W-1:0];
      ALU_SUB:  alu_out_o = a_i - b_i;
      ALU_MUL:  alu_out_o = prod[DATA_W-1:0];
      ALU_DIV:  alu_out_o = (b_i == '0) ? '1 : a_i / b_i;
      ALU_SHL:  alu_out_o = {a_i[DATA_W-2:0], 1'b0};
      ALU_SHR:  alu_out_o = {1'b0, a_i[DATA_W-1:1]};
      ALU_ROL:  alu_out_o = {a_i[DATA_W-2:0], a_i[DATA_W-1]};
      ALU_ROR:  alu_out_o = {a_i[0], a_i[DATA_W-1:1]};
      ALU_AND:  alu_out_o = a_i & b_i;
      ALU_OR:   alu_out_o = a_i | b_i;
      ALU_XOR:  alu_out_o = a_i ^ b_i;
      ALU_NOR:  alu_out_o = ~(a_i | b_i);
      ALU_NAND: alu_out_o = ~(a_i & b_i);
      ALU_XNOR: alu_out_o = ~(a_i ^ b_i);
      ALU_GT:   alu_out_o = {{(DATA_W-1){1'b0}}, (a_i > b_i)};
      ALU_EQ:   alu_out_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
      default:  alu_out_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single shared ALU, one op in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_sel,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [7:0]  resp_out,
  output logic        resp_carry,
  output logic        busy
);

  state_e            state_q, state_d;
  op_t               op_q, op_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              carry_q, carry_d;

  logic              gnt_vld;
  logic              gnt_id;
  logic              take;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;

  // Grant selection: a lone requester wins, a tie goes to the priority holder
  always_comb begin
    gnt_vld = |req_valid;
    gnt_id  = 1'b0;
    if (req_valid == 2'b11) begin
      gnt_id = prio_q;
    end else if (req_valid[1]) begin
      gnt_id = 1'b1;
    end
  end

  assign take = (state_q == IDLE) && gnt_vld;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; ready is only offered while idle
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) req_ready[gnt_id] = 1'b1;
      end
      EXEC: begin
        busy = 1'b1;
      end
      RESP: begin
        busy                = 1'b1;
        resp_valid[owner_q] = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Datapath next values: latch on grant, capture ALU result in EXEC
  always_comb begin
    op_d    = op_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    out_d   = out_q;
    carry_d = carry_q;
    if (take) begin
      op_d.a  = gnt_id ? req_a[15:8]  : req_a[7:0];
      op_d.b  = gnt_id ? req_b[15:8]  : req_b[7:0];
      op_d.sel = gnt_id ? req_sel[7:4] : req_sel[3:0];
      owner_d = gnt_id;
      prio_d  = ~gnt_id;
    end
    if (state_q == EXEC) begin
      out_d   = alu_out;
      carry_d = alu_carry;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      owner_q <= 1'b0;
      prio_q  <= 1'(RR_INIT);
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  alu u_alu (
    .a_i         (op_q.a),
    .b_i         (op_q.b),
    .sel_i       (op_q.sel),
    .alu_out_o   (alu_out),
    .carry_out_o (alu_carry)
  );

  assign resp_out   = out_q;
  assign resp_carry = carry_q;

endmodule
